switch_egress_queue: RTL and testbench
======================================

SWITCH_EGRESS_QUEUE -- requirements
Module: switch_egress_queue

Interface
REQ-001 Parameter: DATA_W, 32, payload width, matching switch dst_data.
REQ-002 Parameter: ADDR_W, 8, address width, matching switch dst_addr.
REQ-003 Parameter: DEPTH, 8, queue entries; power of two, minimum 2.
REQ-004 Parameter: PORT_ADDR, 8'h00, destination address owned by this egress port.
REQ-005 Port: clk, in, 1, single clock; all logic on rising edge.
REQ-006 Port: rst_n, in, 1, asynchronous active-low reset.
REQ-007 Port: in_valid, in, 1, switch output beat present this cycle.
REQ-008 Port: dst_addr, in, ADDR_W, destination address from switch.
REQ-009 Port: dst_data, in, DATA_W, payload from switch.
REQ-010 Port: out_valid, out, 1, head entry available.
REQ-011 Port: out_ready, in, 1, consumer accepts head.
REQ-012 Port: out_addr, out, ADDR_W, head entry address.
REQ-013 Port: out_data, out, DATA_W, head entry payload.
REQ-014 Port: full, out, 1, occupancy equals DEPTH.
REQ-015 Port: empty, out, 1, occupancy equals 0.
REQ-016 Port: level, out, $clog2(DEPTH)+1, current occupancy.
REQ-017 Port: rx_cnt, out, 16, accepted beats, wraps at 0xFFFF to 0.
REQ-018 Port: drop_cnt, out, 16, dropped matching beats, saturates at 0xFFFF.

Function
REQ-019 Match = in_valid && dst_addr == PORT_ADDR; non-matching beats are ignored and never counted.
REQ-020 Pop = out_valid && out_ready; head advances on that edge.
REQ-021 Push = match && (!full || pop); same-cycle pop frees space, so a full queue with pop accepts the beat.
REQ-022 A match with full && !pop is dropped; drop_cnt increments by 1 unless already 0xFFFF.
REQ-023 Every push increments rx_cnt by 1, modulo 2^16.
REQ-024 Occupancy: push only +1; pop only -1; push and pop together leaves it unchanged.
REQ-025 Latency: an accepted beat appears on out_valid/out_addr/out_data on the first edge after acceptance; no combinational in-to-out bypass.
REQ-026 out_addr/out_data hold stable while out_valid && !out_ready.
REQ-027 Ordering is strict FIFO; read and write pointers wrap modulo DEPTH.
REQ-028 Status state machine: EMPTY, PARTIAL, FULL; EMPTY->PARTIAL on push; PARTIAL->FULL when level reaches DEPTH; FULL->PARTIAL on pop without push; PARTIAL->EMPTY when level reaches 0.
REQ-029 full, empty, level and out_valid are registered and consistent with the state on every cycle.
REQ-030 out_data is don't-care when out_valid is 0; the bench does not check it.

Reset
REQ-031 rst_n low immediately clears pointers, level = 0, state = EMPTY, out_valid = 0, full = 0, empty = 1, rx_cnt = 0, drop_cnt = 0.
REQ-032 out_addr and out_data reset to 0.
REQ-033 Reset asserted mid-operation discards all queued entries; no beat is presented after deassertion until a new push.
REQ-034 Inputs sampled on the first rising edge after rst_n deasserts are processed normally.

Structure
REQ-035 Package switch_pkg holds ADDR_W and DATA_W defaults, the beat_t struct {addr, data}, and the queue_state_e enum.
REQ-036 Storage and pointers live in the sub-module egress_fifo; address filter, counters and FSM live in the top module.
REQ-037 Storage is an unreset register array; reset applies to pointers and control only.

Verification
REQ-038 Push 3 beats, addr 8'h00, data 1/2/3, out_ready=1 -> out_data 1,2,3 on consecutive cycles, each one cycle after accept; rx_cnt=3.
REQ-039 Beats with addr 8'h05 interleaved -> never output; rx_cnt and drop_cnt unchanged.
REQ-040 out_ready=0, push 10 matching beats -> full after 8, drop_cnt=2, level=8, head data = first beat.
REQ-041 Full queue, same cycle push 0xAA and pop -> level stays 8, drop_cnt unchanged, 0xAA is the last beat out.
REQ-042 Level 5, assert rst_n low asynchronously mid-cycle -> empty=1, out_valid=0, counters 0 before the next edge.
REQ-043 Force drop_cnt to 0xFFFF, then drop 1 beat -> drop_cnt stays 0xFFFF; force rx_cnt to 0xFFFF, then push 1 beat -> rx_cnt = 0.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the switch egress path: default widths, the queued beat
// record and the occupancy status encoding.
package switch_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } queue_state_e;

endpackage

// File: rtl/egress_fifo.sv
// Storage and pointers for the egress queue. The head entry is mirrored into a
// reset register so the consumer sees a registered, resettable output.
module egress_fifo #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [LW-1:0]     i_level,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]            r_wrPtr;
    logic [PW-1:0]            r_rdPtr;
    logic [PW-1:0]            w_rdNext;
    logic                     w_loadIn;

    assign w_rdNext = r_rdPtr + 1'b1;

    // The incoming beat becomes the head directly when nothing else is ahead of it.
    assign w_loadIn = i_push && ((i_level == '0) || ((i_level == LW'(1)) && i_pop));

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= {i_addr, i_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            o_addr  <= '0;
            o_data  <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_loadIn) begin
                {o_addr, o_data} <= {i_addr, i_data};
            end else if (i_pop && (i_level > LW'(1))) begin
                {o_addr, o_data} <= r_mem[w_rdNext];
            end
        end
    end

endmodule

// File: rtl/switch_egress_queue.sv
// Egress queue for one switch output port: filters beats by destination,
// queues them in FIFO order and tracks accepted/dropped counts.
module switch_egress_queue
    import switch_pkg::*;
#(
    parameter int              DATA_W    = DEF_DATA_W,
    parameter int              ADDR_W    = DEF_ADDR_W,
    parameter int              DEPTH     = 8,
    parameter logic [ADDR_W-1:0] PORT_ADDR = '0,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic [15:0]       rx_cnt,
    output logic [15:0]       drop_cnt
);

    queue_state_e  r_state;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_levelNext;
    logic          r_full;
    logic          r_empty;
    logic          r_outValid;
    logic [15:0]   r_rxCnt;
    logic [15:0]   r_dropCnt;
    logic          w_match;
    logic          w_pop;
    logic          w_push;

    assign w_match = in_valid && (dst_addr == PORT_ADDR);
    assign w_pop   = r_outValid && out_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_push  = w_match && (!r_full || w_pop);

    always_comb begin
        w_levelNext = r_level;
        case ({w_push, w_pop})
            2'b10:   w_levelNext = r_level + LW'(1);
            2'b01:   w_levelNext = r_level - LW'(1);
            default: w_levelNext = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= Q_EMPTY;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            r_level    <= w_levelNext;
            r_full     <= (w_levelNext == LW'(DEPTH));
            r_empty    <= (w_levelNext == '0);
            r_outValid <= (w_levelNext != '0);
            case (r_state)
                Q_EMPTY: begin
                    if (w_push) r_state <= Q_PARTIAL;
                end
                Q_PARTIAL: begin
                    if (w_levelNext == LW'(DEPTH)) r_state <= Q_FULL;
                    else if (w_levelNext == '0)    r_state <= Q_EMPTY;
                end
                Q_FULL: begin
                    if (w_pop && !w_push) r_state <= Q_PARTIAL;
                end
                default: r_state <= Q_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxCnt   <= '0;
            r_dropCnt <= '0;
        end else begin
            if (w_push) begin
                r_rxCnt <= r_rxCnt + 16'd1;
            end
            if (w_match && !w_push && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end
    end

    egress_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_level (r_level),
        .i_addr  (dst_addr),
        .i_data  (dst_data),
        .o_addr  (out_addr),
        .o_data  (out_data)
    );

    assign out_valid = r_outValid;
    assign full      = r_full;
    assign empty     = r_empty;
    assign level     = r_level;
    assign rx_cnt    = r_rxCnt;
    assign drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_switch_egress_queue.sv
// Self-checking bench for switch_egress_queue: directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_switch_egress_queue;
    import switch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  dst_addr;
    logic [31:0] dst_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic [15:0] rx_cnt;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    beat_t       mq[$];
    logic [15:0] mRx;
    logic [15:0] mDrop;

    typedef struct {
        logic        v;
        logic [7:0]  a;
        logic [31:0] d;
        logic        r;
        int          lvl;
        logic        vld;
        logic [31:0] head;
        int          rx;
    } vec_t;

    vec_t tbl[10];

    switch_egress_queue #(
        .DATA_W    (32),
        .ADDR_W    (8),
        .DEPTH     (8),
        .PORT_ADDR (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .rx_cnt    (rx_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, then sample at negedge.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [31:0] d, input logic r);
        logic pop, match, push;
        beat_t b;
        pop   = (mq.size() > 0) && r;
        match = v && (a == 8'h00);
        push  = match && ((mq.size() < 8) || pop);
        in_valid  = v;
        dst_addr  = a;
        dst_data  = d;
        out_ready = r;
        if (pop) void'(mq.pop_front());
        if (push) begin
            b.addr = a;
            b.data = d;
            mq.push_back(b);
            mRx = mRx + 16'd1;
        end
        if (match && !push && (mDrop != 16'hFFFF)) mDrop = mDrop + 16'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".level"}, 32'(level), 32'(mq.size()));
        cmp({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
        cmp({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        cmp({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        cmp({tag, ".rx"}, 32'(rx_cnt), 32'(mRx));
        cmp({tag, ".drop"}, 32'(drop_cnt), 32'(mDrop));
        if (mq.size() > 0) begin
            cmp({tag, ".addr"}, 32'(out_addr), 32'(mq[0].addr));
            cmp({tag, ".data"}, out_data, mq[0].data);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mRx   = '0;
        mDrop = '0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h00, 32'd1,  1'b1, 1, 1'b1, 32'd1, 1};
        tbl[1] = '{1'b1, 8'h00, 32'd2,  1'b1, 1, 1'b1, 32'd2, 2};
        tbl[2] = '{1'b1, 8'h00, 32'd3,  1'b1, 1, 1'b1, 32'd3, 3};
        tbl[3] = '{1'b1, 8'h05, 32'd77, 1'b1, 0, 1'b0, 32'd0, 3};
        tbl[4] = '{1'b1, 8'h05, 32'd88, 1'b0, 0, 1'b0, 32'd0, 3};
        tbl[5] = '{1'b1, 8'h00, 32'd4,  1'b0, 1, 1'b1, 32'd4, 4};
        tbl[6] = '{1'b1, 8'h05, 32'd99, 1'b0, 1, 1'b1, 32'd4, 4};
        tbl[7] = '{1'b0, 8'h00, 32'd5,  1'b0, 1, 1'b1, 32'd4, 4};
        tbl[8] = '{1'b1, 8'h00, 32'd6,  1'b1, 1, 1'b1, 32'd6, 5};
        tbl[9] = '{1'b0, 8'h00, 32'd0,  1'b1, 0, 1'b0, 32'd0, 5};

        rst_n = 1'b0; in_valid = 1'b0; dst_addr = '0; dst_data = '0; out_ready = 1'b0;
        modelReset();
        #12;
        cmp("rst.level", 32'(level), 0);
        cmp("rst.empty", 32'(empty), 1);
        cmp("rst.full", 32'(full), 0);
        cmp("rst.valid", 32'(out_valid), 0);
        cmp("rst.rx", 32'(rx_cnt), 0);
        cmp("rst.drop", 32'(drop_cnt), 0);
        cmp("rst.addr", 32'(out_addr), 0);
        cmp("rst.data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r);
            cmp($sformatf("vec%0d.level", i), 32'(level), 32'(tbl[i].lvl));
            cmp($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].vld));
            cmp($sformatf("vec%0d.rx", i), 32'(rx_cnt), 32'(tbl[i].rx));
            cmp($sformatf("vec%0d.drop", i), 32'(drop_cnt), 0);
            if (tbl[i].vld) cmp($sformatf("vec%0d.head", i), out_data, tbl[i].head);
            checkOutput($sformatf("vec%0d", i));
        end

        // Overfill with the consumer stalled: two beats must be dropped.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'h00, 32'(100 + i), 1'b0);
            checkOutput("fill");
        end
        cmp("fill.level8", 32'(level), 8);
        cmp("fill.full", 32'(full), 1);
        cmp("fill.drop2", 32'(drop_cnt), 2);
        cmp("fill.head", out_data, 32'd100);

        applyStimulus(1'b1, 8'h00, 32'hAA, 1'b1);
        cmp("fullpp.level", 32'(level), 8);
        cmp("fullpp.drop", 32'(drop_cnt), 2);
        checkOutput("fullpp");
        for (int i = 0; i < 8; i++) begin
            if (i == 7) cmp("drain.lastAA", out_data, 32'hAA);
            applyStimulus(1'b0, 8'h00, 32'd0, 1'b1);
            checkOutput("drain");
        end

        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            case ($urandom_range(0, 3))
                0, 1:    a = 8'h00;
                2:       a = 8'h05;
                default: a = 8'($urandom);
            endcase
            applyStimulus(1'($urandom_range(0, 3) != 0), a, $urandom,
                          (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0));
            checkOutput("rand");
        end

        // Asynchronous reset with entries queued, observed before the next edge.
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 8'h00, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h00, 32'(200 + i), 1'b0);
        cmp("pre.level5", 32'(level), 5);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        cmp("arst.empty", 32'(empty), 1);
        cmp("arst.valid", 32'(out_valid), 0);
        cmp("arst.level", 32'(level), 0);
        cmp("arst.rx", 32'(rx_cnt), 0);
        cmp("arst.drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'd0, 1'b1);
        checkOutput("postrst");
        applyStimulus(1'b1, 8'h00, 32'h55, 1'b0);
        checkOutput("postrst.push");

        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h00, 32'(300 + i), 1'b0);
        cmp("sat.full", 32'(full), 1);
        force dut.r_dropCnt = 16'hFFFF;
        #1 release dut.r_dropCnt;
        mDrop = 16'hFFFF;
        applyStimulus(1'b1, 8'h00, 32'h11, 1'b0);
        cmp("sat.drop", 32'(drop_cnt), 32'h0000FFFF);
        force dut.r_rxCnt = 16'hFFFF;
        #1 release dut.r_rxCnt;
        mRx = 16'hFFFF;
        applyStimulus(1'b1, 8'h00, 32'h22, 1'b1);
        cmp("wrap.rx", 32'(rx_cnt), 0);
        checkOutput("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
